ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Programming-side driver for the fabric configuration chains: the writer end of the ccff_head/ccff_tail/prog_clock interface on fpga_top.
- Accepts configuration columns over a valid/ready stream, one bit per chain per beat.
- Shifts the columns into NUM_CHAINS parallel chains with a generated prog_clock, then reports completion.
- Replaces backdoor bitstream loading in benches and is the RTL front end for on-chip programming.

Parameters:
NUM_CHAINS, 10, number of parallel configuration chains (width of ccff_head/ccff_tail)
CHAIN_LEN, 2048, bits per chain; one chain-column beat per bit
PROG_HALF, 2, clk cycles per prog_clock half period (>=1)
CNT_W, $clog2(CHAIN_LEN+1), width of bit counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load when idle
s_valid  in  1  column beat valid
s_ready  out  1  column beat accepted when s_valid&&s_ready
s_data  in  NUM_CHAINS  bit i goes to chain i
ccff_head  out  NUM_CHAINS  serial data into chains
ccff_tail  in  NUM_CHAINS  serial data out of chains
prog_clock  out  1  generated configuration shift clock
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of load
bit_count  out  CNT_W  columns shifted so far

Behaviour:
- Reset: state IDLE; prog_clock=0, ccff_head=0, s_ready=0, busy=0, done=0, bit_count=0. A reset mid-load aborts immediately. Chains keep partial contents; no further prog_clock edge.
- States: IDLE, FETCH, SETUP, HIGH, DONE.
- IDLE: start=1 -> FETCH, busy=1, bit_count=0. start while busy is ignored.
- FETCH: prog_clock=0, s_ready=1.
  - On handshake: ccff_head<=s_data, s_ready drops next cycle -> SETUP.
  - No s_valid: stay; prog_clock held low (stall, no edge).
- SETUP: prog_clock low for PROG_HALF cycles, counting the handshake cycle as the first -> HIGH.
- HIGH: prog_clock=1 for PROG_HALF cycles. The chains sample on the 0->1 edge. bit_count increments on entry to HIGH.
  - Exit when bit_count==CHAIN_LEN -> DONE.
  - Otherwise -> FETCH with prog_clock=0.
- Maximum throughput: one column per 2*PROG_HALF clk cycles; prog_clock duty cycle 50% when unstalled.
- DONE: prog_clock=0, done=1 for one cycle, busy=0 -> IDLE. ccff_head holds the last column.
- Ordering: the first accepted column exits the far end first. After the load, column k (0-based) sits at chain position CHAIN_LEN-1-k.
- s_valid in IDLE/DONE is not accepted (s_ready=0). Extra beats stay on the interface.
- bit_count never exceeds CHAIN_LEN and holds its value after DONE until the next start.

Optional Feature:
- Macro CCFF_READBACK_EN.
- Adds outputs verify_ok and verify_fail (1 bit each, reset 0).
- During load: a CRC-16-CCITT (init 0xFFFF) is computed over the columns, each column fed LSB-first per chain index.
- After the last HIGH, VERIFY state: CHAIN_LEN further prog_clock pulses with ccff_head<=ccff_tail (recirculation). The configuration is unchanged afterwards.
- A second CRC is computed over ccff_tail sampled in SETUP, one cycle before each rising edge.
- DONE asserts verify_ok or verify_fail (one-cycle pulse, together with done).
- Without the macro: no VERIFY state, no extra ports, ccff_tail unused.

Decomposition:
- Package ccff_pkg holds:
  - state enum (IDLE, FETCH, SETUP, HIGH, VERIFY, DONE);
  - CRC16 polynomial 16'h1021 and init 16'hFFFF;
  - a function crc16_step(crc, column).
- Sub-module ccff_prog_clk_gen: half-period counter producing prog_clock phase strobes (setup_end, high_end) from a run/stall input.

Test Plan:
- Reset mid-load: NUM_CHAINS=2, CHAIN_LEN=4, PROG_HALF=1; reset after 2 beats -> prog_clock=0, busy=0, bit_count=0 next cycle; no further edges.
- Normal load: same parameters, beats 2'b01,2'b10,2'b11,2'b00 with s_valid held high -> exactly 4 prog_clock rising edges; chain0 contents {1,0,1,0} far-to-near; done pulses 9 cycles after start; bit_count=4.
- Stall: s_valid low for 5 cycles before beat 3 -> prog_clock stays low throughout; total edges still 4; ccff_head stable during the stall.
- Start during busy: pulse start during beat 2 -> ignored; single done pulse; bit_count=4.
- With CCFF_READBACK_EN, behavioural chain model: after load -> 4 recirculation edges, verify_ok=1; chain contents identical before and after VERIFY.
- With CCFF_READBACK_EN, tail bit forced to 1 during VERIFY -> verify_fail=1, verify_ok=0.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and CRC helper for the configuration chain loader.
package ccff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        HIGH,
        VERIFY,
        DONE
    } state_e;

    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam int          CRC_MAX_COLS = 64;

    // One column through CRC-16-CCITT, chain 0 first; columns wider than CRC_MAX_COLS are not supported.
    function automatic logic [15:0] crc16_step(input logic [15:0]             crc,
                                               input logic [CRC_MAX_COLS-1:0] column,
                                               input int                      width);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < CRC_MAX_COLS; i++) begin
            if (i < width) begin
                fb = c[15] ^ column[i];
                c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ccff_prog_clk_gen.sv
// Half-period counter for prog_clock: strobes the last cycle of the low (setup_end) or high (high_end) phase.
// Counter restarts whenever run_i drops, so a stalled low phase is timed from the cycle the data arrives.
module ccff_prog_clk_gen #(
    parameter int PROG_HALF = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic phase_i,
    output logic setup_end_o,
    output logic high_end_o
);

    localparam int HW = (PROG_HALF > 1) ? $clog2(PROG_HALF) : 1;

    logic [HW-1:0] cnt_q, cnt_d;
    logic          last;

    assign last        = (cnt_q == HW'(PROG_HALF - 1));
    assign setup_end_o = run_i && !phase_i && last;
    assign high_end_o  = run_i &&  phase_i && last;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Shifts stream columns into NUM_CHAINS config chains, one column per 2*PROG_HALF clk; s_ready only in FETCH,
// a missing beat holds prog_clock low. Define CCFF_READBACK_EN for CRC-checked recirculation readback.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int NUM_CHAINS = 10,
    parameter int CHAIN_LEN  = 2048,
    parameter int PROG_HALF  = 2,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [NUM_CHAINS-1:0] s_data,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  prog_clock,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      bit_count
`ifdef CCFF_READBACK_EN
    ,
    output logic                  verify_ok,
    output logic                  verify_fail
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN);

    state_e                state_q, state_d;
    logic [NUM_CHAINS-1:0] head_q, head_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pclk_q, pclk_d;
    logic                  gen_run, setup_end, high_end;

`ifdef CCFF_READBACK_EN
    logic [15:0]      crc_l_q, crc_l_d;
    logic [15:0]      crc_v_q, crc_v_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
`else
    logic unused_tail;
    assign unused_tail = ^ccff_tail;
`endif

    always_comb begin
        gen_run = 1'b0;
        case (state_q)
            FETCH:               gen_run = s_valid;
            SETUP, HIGH, VERIFY: gen_run = 1'b1;
            default:             gen_run = 1'b0;
        endcase
    end

    // pclk_q doubles as the phase select: it is high exactly during the high half period.
    ccff_prog_clk_gen #(
        .PROG_HALF (PROG_HALF)
    ) u_clk_gen (
        .clk_i       (clk),
        .reset_i     (reset),
        .run_i       (gen_run),
        .phase_i     (pclk_q),
        .setup_end_o (setup_end),
        .high_end_o  (high_end)
    );

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        cnt_d   = cnt_q;
        pclk_d  = 1'b0;
`ifdef CCFF_READBACK_EN
        crc_l_d = crc_l_q;
        crc_v_d = crc_v_q;
        vcnt_d  = vcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
`ifdef CCFF_READBACK_EN
                    crc_l_d = CRC16_INIT;
                    crc_v_d = CRC16_INIT;
                    vcnt_d  = '0;
`endif
                end
            end
            FETCH: begin
                if (s_valid) begin
                    head_d = s_data;
`ifdef CCFF_READBACK_EN
                    crc_l_d = crc16_step(crc_l_q, CRC_MAX_COLS'(s_data), NUM_CHAINS);
`endif
                    // The handshake cycle is the first low cycle; PROG_HALF=1 goes straight to HIGH.
                    if (setup_end) begin
                        state_d = HIGH;
                        pclk_d  = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (setup_end) begin
                    state_d = HIGH;
                    pclk_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                pclk_d = 1'b1;
                if (high_end) begin
                    pclk_d = 1'b0;
                    if (cnt_q == LAST) begin
`ifdef CCFF_READBACK_EN
                        state_d = VERIFY;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
`ifdef CCFF_READBACK_EN
            VERIFY: begin
                pclk_d = pclk_q;
                // Tail is still the pre-shift far-end bit here, so feeding it back rotates each chain by one.
                if (setup_end) begin
                    head_d  = ccff_tail;
                    crc_v_d = crc16_step(crc_v_q, CRC_MAX_COLS'(ccff_tail), NUM_CHAINS);
                    vcnt_d  = vcnt_q + 1'b1;
                    pclk_d  = 1'b1;
                end
                if (high_end) begin
                    pclk_d = 1'b0;
                    if (vcnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            cnt_q   <= '0;
            pclk_q  <= 1'b0;
`ifdef CCFF_READBACK_EN
            crc_l_q <= CRC16_INIT;
            crc_v_q <= CRC16_INIT;
            vcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            pclk_q  <= pclk_d;
`ifdef CCFF_READBACK_EN
            crc_l_q <= crc_l_d;
            crc_v_q <= crc_v_d;
            vcnt_q  <= vcnt_d;
`endif
        end
    end

    assign s_ready    = (state_q == FETCH);
    assign busy       = (state_q == FETCH) || (state_q == SETUP) ||
                        (state_q == HIGH)  || (state_q == VERIFY);
    assign done       = (state_q == DONE);
    assign ccff_head  = head_q;
    assign prog_clock = pclk_q;
    assign bit_count  = cnt_q;

`ifdef CCFF_READBACK_EN
    assign verify_ok   = (state_q == DONE) && (crc_l_q == crc_v_q);
    assign verify_fail = (state_q == DONE) && (crc_l_q != crc_v_q);
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: 2 chains of 4 bits, PROG_HALF=1, with a behavioural chain model.
`timescale 1ns/1ps

`define CHK(TAG, OBS, EXP) \
    begin \
        n_checks++; \
        assert ((OBS) === (EXP)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

module tb_ccff_chain_loader;

    localparam int NC = 2;
    localparam int CL = 4;
    localparam int PH = 1;
    localparam int CW = $clog2(CL + 1);
`ifdef CCFF_READBACK_EN
    localparam int EXTRA = 2 * CL;
    localparam int EPL   = 2 * CL;
`else
    localparam int EXTRA = 0;
    localparam int EPL   = CL;
`endif

    logic          clk = 1'b0;
    logic          reset, start, s_valid, s_ready;
    logic [NC-1:0] s_data, ccff_head, ccff_tail;
    logic          prog_clock, busy, done;
    logic [CW-1:0] bit_count;
`ifdef CCFF_READBACK_EN
    logic          verify_ok, verify_fail;
    int            ok_cnt, fail_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [CL-1:0] ch0 = '0;
    logic [CL-1:0] ch1 = '0;
    logic          pc_prev = 1'b0;
    int            edges = 0;
    bit            force_tail = 1'b0;

    logic [NC-1:0] beats [4];
    int            done_cyc, done_cnt, stall_bad_pc, stall_bad_head, idx, e0;
    logic [CW-1:0] cnt_at2;
    logic [15:0]   pc_trace, busy_trace;

    always #5 clk = ~clk;

    ccff_chain_loader #(
        .NUM_CHAINS (NC),
        .CHAIN_LEN  (CL),
        .PROG_HALF  (PH),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .ccff_head  (ccff_head),
        .ccff_tail  (ccff_tail),
        .prog_clock (prog_clock),
        .busy       (busy),
        .done       (done),
        .bit_count  (bit_count)
`ifdef CCFF_READBACK_EN
        ,
        .verify_ok  (verify_ok),
        .verify_fail(verify_fail)
`endif
    );

    // Chains shift the head bit in on each prog_clock rising edge; far end (bit CL-1) drives the tail.
    assign ccff_tail = force_tail ? {NC{1'b1}} : {ch1[CL-1], ch0[CL-1]};

    always @(negedge clk) begin
        pc_prev <= prog_clock;
        if (prog_clock && !pc_prev) begin
            edges <= edges + 1;
            ch0   <= {ch0[CL-2:0], ccff_head[0]};
            ch1   <= {ch1[CL-2:0], ccff_head[1]};
        end
    end

    task automatic run_load(input int stall_len, input bit poke_start, input int abort_at);
        int            stall_left;
        logic [NC-1:0] held;
        idx = 0; stall_left = stall_len; held = '0;
        done_cyc = -1; done_cnt = 0; stall_bad_pc = 0; stall_bad_head = 0;
        pc_trace = '0; busy_trace = '0; cnt_at2 = '0;
`ifdef CCFF_READBACK_EN
        ok_cnt = 0; fail_cnt = 0;
`endif
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = poke_start && (cyc == 3);
            if (cyc < 16) begin
                pc_trace[cyc]   = prog_clock;
                busy_trace[cyc] = busy;
            end
            if (cyc == 2) cnt_at2 = bit_count;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
`ifdef CCFF_READBACK_EN
            if (verify_ok)   ok_cnt++;
            if (verify_fail) fail_cnt++;
`endif
            if (abort_at >= 0 && idx == abort_at) begin
                reset   = 1'b1;
                s_valid = 1'b0;
                return;
            end
            if (idx == 2 && stall_left > 0) begin
                if (stall_left < stall_len) begin
                    if (prog_clock !== 1'b0) stall_bad_pc++;
                    if (ccff_head !== held)  stall_bad_head++;
                end else begin
                    held = ccff_head;
                end
                stall_left--;
                s_valid = 1'b0;
                s_data  = 2'b11;
            end else if (idx < 4) begin
                s_valid = 1'b1;
                s_data  = beats[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = 2'b11;
            end
            if (s_valid && s_ready) idx++;
        end
        s_valid = 1'b0;
    endtask

    initial begin
        beats[0] = 2'b01; beats[1] = 2'b10; beats[2] = 2'b11; beats[3] = 2'b00;
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        `CHK("rst_prog_clock", prog_clock, 1'b0)
        `CHK("rst_head", ccff_head, 2'b00)
        `CHK("rst_s_ready", s_ready, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_bit_count", bit_count, 3'd0)
        reset = 1'b0;

        // Reset after two accepted beats.
        run_load(0, 1'b0, 2);
        @(negedge clk);
        `CHK("abort_prog_clock", prog_clock, 1'b0)
        `CHK("abort_busy", busy, 1'b0)
        `CHK("abort_bit_count", bit_count, 3'd0)
        `CHK("abort_head", ccff_head, 2'b00)
        reset   = 1'b0;
        s_valid = 1'b1;
        s_data  = 2'b11;
        repeat (6) @(negedge clk);
        `CHK("abort_edges", edges, 2)
        `CHK("abort_idle_ready", s_ready, 1'b0)
        `CHK("abort_partial_ch0", ch0[1:0], 2'b10)
        `CHK("abort_partial_ch1", ch1[1:0], 2'b01)
        s_valid = 1'b0;

        // Normal load, s_valid always high.
        e0 = edges;
        run_load(0, 1'b0, -1);
        `CHK("norm_edges", edges - e0, EPL)
        `CHK("norm_ch0", ch0, 4'b1010)
        `CHK("norm_ch1", ch1, 4'b0110)
        `CHK("norm_done_cyc", done_cyc, 9 + EXTRA)
        `CHK("norm_done_cnt", done_cnt, 1)
        `CHK("norm_bit_count", bit_count, 3'd4)
        `CHK("norm_cnt_first_high", cnt_at2, 3'd1)
        `CHK("norm_pc_trace", pc_trace[9:0], 10'h154)
        `CHK("norm_busy_trace", busy_trace[8:0], 9'h1FE)
        `CHK("norm_busy_after", busy, 1'b0)
        `CHK("norm_head_last", ccff_head, 2'b00)

        // Five-cycle gap before the third beat.
        e0 = edges;
        run_load(5, 1'b0, -1);
        `CHK("stall_edges", edges - e0, EPL)
        `CHK("stall_pc_low", stall_bad_pc, 0)
        `CHK("stall_head_stable", stall_bad_head, 0)
        `CHK("stall_done_cyc", done_cyc, 13 + EXTRA)
        `CHK("stall_ch0", ch0, 4'b1010)
        `CHK("stall_ch1", ch1, 4'b0110)

        // Start pulse while busy is ignored.
        e0 = edges;
        run_load(0, 1'b1, -1);
        `CHK("poke_done_cnt", done_cnt, 1)
        `CHK("poke_done_cyc", done_cyc, 9 + EXTRA)
        `CHK("poke_bit_count", bit_count, 3'd4)
        `CHK("poke_edges", edges - e0, EPL)

        // Beats offered while idle stay on the interface.
        e0      = edges;
        s_valid = 1'b1;
        s_data  = 2'b11;
        repeat (3) @(negedge clk);
        `CHK("idle_ready", s_ready, 1'b0)
        `CHK("idle_head", ccff_head, 2'b00)
        `CHK("idle_bit_count", bit_count, 3'd4)
        `CHK("idle_edges", edges - e0, 0)
        s_valid = 1'b0;

`ifdef CCFF_READBACK_EN
        // Load, recirculate and compare against the loaded image.
        run_load(0, 1'b0, -1);
        `CHK("rb_ok", ok_cnt, 1)
        `CHK("rb_no_fail", fail_cnt, 0)
        `CHK("rb_ch0_kept", ch0, 4'b1010)
        `CHK("rb_ch1_kept", ch1, 4'b0110)

        force_tail = 1'b1;
        run_load(0, 1'b0, -1);
        force_tail = 1'b0;
        `CHK("rb_forced_fail", fail_cnt, 1)
        `CHK("rb_forced_no_ok", ok_cnt, 0)
        `CHK("rb_forced_done_cyc", done_cyc, 9 + EXTRA)
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
